// File: rtl/crtc_pkg.sv
// Shared definitions for the CRT timing controller: default counter width,
// the VGA 640x480 character-clock mode and the raster region encoding.
package crtc_pkg;

    localparam int CRTC_WIDTH = 32'd10;

    // VGA 640x480 in 8-pixel characters; each value is the last count of its region
    localparam logic [9:0] VGA_H_SYNC   = 10'd11;
    localparam logic [9:0] VGA_H_BPORCH = 10'd17;
    localparam logic [9:0] VGA_H_ACTIVE = 10'd97;
    localparam logic [9:0] VGA_H_FPORCH = 10'd99;
    localparam logic [9:0] VGA_V_SYNC   = 10'd1;
    localparam logic [9:0] VGA_V_BPORCH = 10'd34;
    localparam logic [9:0] VGA_V_ACTIVE = 10'd514;
    localparam logic [9:0] VGA_V_FPORCH = 10'd524;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BPORCH = 2'd1,
        ACTIVE = 2'd2,
        FPORCH = 2'd3
    } region_e;

endpackage

// File: rtl/crtc_axis.sv
// One raster axis: a counter wrapping at the front-porch boundary plus registered
// sync/blank/index decode. CRTC_NEG_SYNC_EN selects an active-low sync output.
module crtc_axis
    import crtc_pkg::*;
#(
    parameter int WIDTH = CRTC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             advance,
    input  logic [WIDTH-1:0] sync_last,
    input  logic [WIDTH-1:0] bporch_last,
    input  logic [WIDTH-1:0] active_last,
    input  logic [WIDTH-1:0] fporch_last,
    output logic             sync,
    output logic             blank,
    output logic             blank_next,
    output logic [WIDTH-1:0] index,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] index_r;
    logic [WIDTH-1:0] index_s;
    logic             sync_r;
    logic             sync_s;
    logic             blank_r;
    logic             blank_s;
    region_e          region_s;

    // Active wins over the other regions so blanking follows its own window compare
    // even when the boundaries are programmed out of order.
    function automatic region_e decode_region(input logic [WIDTH-1:0] cnt,
                                              input logic [WIDTH-1:0] s_last,
                                              input logic [WIDTH-1:0] b_last,
                                              input logic [WIDTH-1:0] a_last);
        region_e r;
        if ((cnt > b_last) && (cnt <= a_last)) begin
            r = ACTIVE;
        end else if (cnt <= s_last) begin
            r = SYNC;
        end else if (cnt <= b_last) begin
            r = BPORCH;
        end else begin
            r = FPORCH;
        end
        return r;
    endfunction

    // Next count and decode of that next count, so the registered outputs line up with the counter.
    always_comb begin
        wrap    = (cnt_r >= fporch_last);
        cnt_s   = cnt_r;
        index_s = {WIDTH{1'b0}};
        if (advance) begin
            if (wrap) begin
                cnt_s = {WIDTH{1'b0}};
            end else begin
                cnt_s = cnt_r + WIDTH'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
        region_s = decode_region(cnt_s, sync_last, bporch_last, active_last);
`ifdef CRTC_NEG_SYNC_EN
        sync_s   = !(cnt_s <= sync_last);
`else
        sync_s   = (cnt_s <= sync_last);
`endif
        blank_s  = (region_s != ACTIVE);
        if (region_s == ACTIVE) begin
            index_s = cnt_s - bporch_last - WIDTH'(1);
        end else begin
            index_s = {WIDTH{1'b0}};
        end
    end

    // Counter and output registers; everything holds while enable is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r   <= {WIDTH{1'b0}};
            sync_r  <= 1'b1;
            blank_r <= 1'b1;
            index_r <= {WIDTH{1'b0}};
        end else if (enable) begin
            cnt_r   <= cnt_s;
            sync_r  <= sync_s;
            blank_r <= blank_s;
            index_r <= index_s;
        end
    end

    assign sync       = sync_r;
    assign blank      = blank_r;
    assign blank_next = blank_s;
    assign index      = index_r;

endmodule

// File: rtl/crtc_timing.sv
// Character-clock CRT timing generator: horizontal and vertical axes with registered
// sync, blank, display enable and active-area coordinates. CRTC_NEG_SYNC_EN: active-low syncs.
module crtc_timing
    import crtc_pkg::*;
#(
    parameter int WIDTH = CRTC_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] hsynct_i,
    input  logic [WIDTH-1:0] hbporch_i,
    input  logic [WIDTH-1:0] hactive_i,
    input  logic [WIDTH-1:0] hfporch_i,
    input  logic [WIDTH-1:0] vsynct_i,
    input  logic [WIDTH-1:0] vbporch_i,
    input  logic [WIDTH-1:0] vactive_i,
    input  logic [WIDTH-1:0] vfporch_i,
    output logic [WIDTH-1:0] row_o,
    output logic [WIDTH-1:0] col_o,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             hblank_o,
    output logic             vblank_o
);

    logic h_wrap_s;
    logic v_wrap_unused_s;
    logic h_blank_next_s;
    logic v_blank_next_s;
    logic de_r;

    crtc_axis #(.WIDTH(WIDTH)) u_haxis (
        .clock       (clock_i),
        .reset       (reset_i),
        .enable      (enable_i),
        .advance     (enable_i),
        .sync_last   (hsynct_i),
        .bporch_last (hbporch_i),
        .active_last (hactive_i),
        .fporch_last (hfporch_i),
        .sync        (hsync_o),
        .blank       (hblank_o),
        .blank_next  (h_blank_next_s),
        .index       (col_o),
        .wrap        (h_wrap_s)
    );

    // The line counter steps only on the character that ends a line.
    crtc_axis #(.WIDTH(WIDTH)) u_vaxis (
        .clock       (clock_i),
        .reset       (reset_i),
        .enable      (enable_i),
        .advance     (enable_i & h_wrap_s),
        .sync_last   (vsynct_i),
        .bporch_last (vbporch_i),
        .active_last (vactive_i),
        .fporch_last (vfporch_i),
        .sync        (vsync_o),
        .blank       (vblank_o),
        .blank_next  (v_blank_next_s),
        .index       (row_o),
        .wrap        (v_wrap_unused_s)
    );

    // Display enable registered from both axes' next blanking so it matches them cycle for cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            de_r <= 1'b0;
        end else if (enable_i) begin
            de_r <= !h_blank_next_s && !v_blank_next_s;
        end
    end

    assign de_o = de_r;

endmodule

// File: tb/tb_crtc_timing.sv
// Self-checking bench for crtc_timing in VGA 640x480 mode: vector table, closed-form
// raster model under random enable, and directed reset / enable / mode-change sequences.
module tb_crtc_timing;

`ifdef CRTC_NEG_SYNC_EN
    localparam bit NEG = 1'b1;
`else
    localparam bit NEG = 1'b0;
`endif
    localparam int H_SYNC = 11, H_BP = 17, H_ACT = 97, H_TOT = 100;
    localparam int V_SYNC = 1,  V_BP = 34, V_ACT = 514, V_TOT = 525;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic [9:0] hsynct_i, hbporch_i, hactive_i, hfporch_i;
    logic [9:0] vsynct_i, vbporch_i, vactive_i, vfporch_i;
    logic [9:0] row_o, col_o;
    logic       de_o, hsync_o, vsync_o, hblank_o, vblank_o;

    crtc_timing #(.WIDTH(10)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .hsynct_i(hsynct_i), .hbporch_i(hbporch_i), .hactive_i(hactive_i), .hfporch_i(hfporch_i),
        .vsynct_i(vsynct_i), .vbporch_i(vbporch_i), .vactive_i(vactive_i), .vfporch_i(vfporch_i),
        .row_o(row_o), .col_o(col_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .hblank_o(hblank_o), .vblank_o(vblank_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
        logic [9:0] row;
        logic [9:0] col;
    } obs_t;

    typedef struct {
        int   t;
        obs_t exp;
    } vec_t;

    localparam obs_t RST = '{hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1, de: 1'b0, row: 10'd0, col: 10'd0};

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;   // enabled edges since the last reset release

    // Raster position -> outputs, straight from the region definitions.
    function automatic obs_t model_hv(int h, int v);
        obs_t o;
        bit   hact, vact;
        hact  = (h > H_BP) && (h <= H_ACT);
        vact  = (v > V_BP) && (v <= V_ACT);
        o.hs  = (h <= H_SYNC) ^ NEG;
        o.vs  = (v <= V_SYNC) ^ NEG;
        o.hb  = !hact;
        o.vb  = !vact;
        o.de  = hact && vact;
        o.col = hact ? 10'(h - H_BP - 1) : 10'd0;
        o.row = vact ? 10'(v - V_BP - 1) : 10'd0;
        return o;
    endfunction

    function automatic obs_t model(int tt);
        return model_hv(tt % H_TOT, (tt / H_TOT) % V_TOT);
    endfunction

    function automatic vec_t mk(int tt, bit hs, bit vs, bit hb, bit vb, bit de, int row, int col);
        vec_t r;
        r.t   = tt;
        r.exp = '{hs: hs ^ NEG, vs: vs ^ NEG, hb: hb, vb: vb, de: de, row: 10'(row), col: 10'(col)};
        return r;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.hs = hsync_o; o.vs = vsync_o; o.hb = hblank_o; o.vb = vblank_o;
        o.de = de_o; o.row = row_o; o.col = col_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = cur();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got hs=%0b vs=%0b hb=%0b vb=%0b de=%0b row=%0d col=%0d want hs=%0b vs=%0b hb=%0b vb=%0b de=%0b row=%0d col=%0d",
                     name, t, got.hs, got.vs, got.hb, got.vb, got.de, got.row, got.col,
                     exp.hs, exp.vs, exp.hb, exp.vb, exp.de, exp.row, exp.col);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit en);
        enable_i = en;
        @(posedge clock_i);
        #1;
        if (en) t++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        int   hs_cnt, hb_low, hb_first, bad_col, vs_cnt, lines, row_max, bad_row, vprev;

        reset_i  = 1'b1;
        enable_i = 1'b0;
        hsynct_i = 10'd11; hbporch_i = 10'd17; hactive_i = 10'd97;  hfporch_i = 10'd99;
        vsynct_i = 10'd1;  vbporch_i = 10'd34; vactive_i = 10'd514; vfporch_i = 10'd524;
        #12;
        check("reset_state", RST);
        reset_i = 1'b0;
        t = 0;

        // position checkpoints (sync given active-high, flipped by mk for the inverted build)
        tbl[0]  = mk(1,    1, 1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(11,   1, 1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(12,   0, 1, 1, 1, 0, 0, 0);
        tbl[3]  = mk(17,   0, 1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(18,   0, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(19,   0, 1, 0, 1, 0, 0, 1);
        tbl[6]  = mk(97,   0, 1, 0, 1, 0, 0, 79);
        tbl[7]  = mk(98,   0, 1, 1, 1, 0, 0, 0);
        tbl[8]  = mk(100,  1, 1, 1, 1, 0, 0, 0);
        tbl[9]  = mk(200,  1, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(3518, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(3597, 0, 0, 0, 0, 1, 0, 79);
        tbl[12] = mk(3650, 0, 0, 0, 0, 1, 1, 32);
        for (int i = 0; i < 13; i++) begin
            while (t < tbl[i].t) step(1'b1);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // one full active line, sampled from its first character
        while (t % H_TOT != 0) step(1'b1);
        hs_cnt = 0; hb_low = 0; hb_first = -1; bad_col = 0;
        for (int i = 0; i < H_TOT; i++) begin
            if (hsync_o ^ NEG) hs_cnt++;
            if (!hblank_o) begin
                if (hb_first < 0) hb_first = i;
                hb_low++;
                if (col_o != 10'(i - 18)) bad_col++;
            end else if (col_o != 10'd0) begin
                bad_col++;
            end
            step(1'b1);
        end
        check_int("line_hsync_len", hs_cnt, 12);
        check_int("line_active_len", hb_low, 80);
        check_int("line_active_start", hb_first, 18);
        check_int("line_col_seq", bad_col, 0);

        // enable dropped mid-active: everything frozen, then resumes from the same column
        while (t % H_TOT != 58) step(1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            check("enable_hold", model(t));
        end
        step(1'b1);
        check("enable_resume", model(t));
        check_int("enable_resume_col", col_o, 41);

        // random enable against the closed-form model
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(3, 0) != 0);
            check("random", model(t));
        end

        // line length shrunk below the current count: wrap on the next edge, one line step
        while (t % H_TOT != 80) step(1'b1);
        vprev = (t / H_TOT) % V_TOT;
        hfporch_i = 10'd49;
        step(1'b1);
        check("mode_wrap", model_hv(0, (vprev + 1) % V_TOT));
        step(1'b1);
        check("mode_next", model_hv(1, (vprev + 1) % V_TOT));
        hfporch_i = 10'd99;

        // asynchronous reset mid-line, with enable still high
        repeat (37) step(1'b1);
        #2 reset_i = 1'b1;
        #1 check("reset_async", RST);
        #8 check("reset_hold", RST);
        reset_i = 1'b0;
        t = 0;

        // one complete frame from reset release
        hs_cnt = 0; vs_cnt = 0; lines = 0; row_max = 0; bad_row = 0;
        for (int i = 1; i <= H_TOT * V_TOT; i++) begin
            step(1'b1);
            check("frame", model(t));
            if (i <= H_TOT && (hsync_o ^ NEG)) hs_cnt++;
            if (vsync_o ^ NEG) vs_cnt++;
            if (de_o && col_o == 10'd0) begin
                if (row_o != 10'(lines)) bad_row++;
                if (int'(row_o) > row_max) row_max = int'(row_o);
                lines++;
            end
        end
        check_int("frame_hsync_len", hs_cnt, 12);
        check_int("frame_vsync_len", vs_cnt, 200);
        check_int("frame_de_lines", lines, 480);
        check_int("frame_row_max", row_max, 479);
        check_int("frame_row_seq", bad_row, 0);
        check_int("frame_period", t % (H_TOT * V_TOT), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
